regfile_access_unit: RTL and testbench

- Initiator side of the 32x32 register file port set. Drives ReadRegister1/ReadRegister2/WriteRegister/WriteData/RegWrite.
- Accepts operand-fetch requests from decode and returns operands over a valid/ready handshake.
- Accepts writeback requests from the execute/memory stage, queues them, and drains them to the write port.
- Bypasses queued writebacks into fetched operands so callers always see program-order register values.

---
 rtl/regfile_access_unit.sv | 209 ++++++++++++++++++++
 tb/tb_regfile_access_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_unit.sv
// regfile_access_unit: initiator for a 32x32 register file. Fetches two
// operands per request through a fixed four-state sequence, queues
// writebacks in a small FIFO drained to the write port, and bypasses
// queued or in-flight writebacks so that fetched operands see
// program-order register values.
module regfile_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WB_DEPTH   = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [ADDR_WIDTH-1:0] InRs,
  input  logic [ADDR_WIDTH-1:0] InRt,
  input  logic [ADDR_WIDTH-1:0] InRd,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] Op1,
  output logic [DATA_WIDTH-1:0] Op2,
  output logic [ADDR_WIDTH-1:0] OutRd,
  input  logic                  WbValid,
  output logic                  WbReady,
  input  logic [ADDR_WIDTH-1:0] WbReg,
  input  logic [DATA_WIDTH-1:0] WbData,
  input  logic                  Freeze,
  output logic [ADDR_WIDTH-1:0] ReadRegister1,
  output logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [DATA_WIDTH-1:0] ReadData1,
  input  logic [DATA_WIDTH-1:0] ReadData2,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rr1_q, rr1_d, rr2_q, rr2_d, out_rd_q, out_rd_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic                    out_valid_q, out_valid_d;

  logic [ADDR_WIDTH-1:0]   q_reg_q  [WB_DEPTH];
  logic [ADDR_WIDTH-1:0]   q_reg_d  [WB_DEPTH];
  logic [DATA_WIDTH-1:0]   q_data_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0]   q_data_d [WB_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic                    full_s, empty_s, wb_accept_s, wb_push_s, wb_pop_s;
  logic [DATA_WIDTH-1:0]   byp1_s, byp2_s;

  // Queue status and head-of-queue drain onto the register file write port.
  always_comb begin
    full_s        = (count_q == CNT_W'(WB_DEPTH));
    empty_s       = (count_q == {CNT_W{1'b0}});
    wb_accept_s   = WbValid & ~full_s;
    // Index-0 writebacks are acknowledged but never stored.
    wb_push_s     = wb_accept_s & (WbReg != {ADDR_WIDTH{1'b0}});
    wb_pop_s      = ~empty_s & ~Freeze;
    WbReady       = ~full_s;
    RegWrite      = wb_pop_s;
    WriteRegister = q_reg_q[rd_ptr_q];
    WriteData     = q_data_q[rd_ptr_q];
  end

  // Queue next-state: store on push, advance pointers, track occupancy.
  always_comb begin
    q_reg_d  = q_reg_q;
    q_data_d = q_data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wb_push_s) begin
      q_reg_d[wr_ptr_q]  = WbReg;
      q_data_d[wr_ptr_q] = WbData;
      wr_ptr_d           = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (wb_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wb_push_s, wb_pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Operand bypass: incoming writeback, then youngest queued entry, then file data.
  always_comb begin
    byp1_s = ReadData1;
    byp2_s = ReadData2;
    // Walk oldest to youngest so the youngest match wins.
    for (int i = 0; i < WB_DEPTH; i++) begin
      byp1_s = ((CNT_W'(i) < count_q) && (q_reg_q[rd_ptr_q + PTR_W'(i)] == rr1_q))
               ? q_data_q[rd_ptr_q + PTR_W'(i)] : byp1_s;
      byp2_s = ((CNT_W'(i) < count_q) && (q_reg_q[rd_ptr_q + PTR_W'(i)] == rr2_q))
               ? q_data_q[rd_ptr_q + PTR_W'(i)] : byp2_s;
    end
    byp1_s = (wb_push_s && (WbReg == rr1_q)) ? WbData : byp1_s;
    byp2_s = (wb_push_s && (WbReg == rr2_q)) ? WbData : byp2_s;
    byp1_s = (rr1_q == {ADDR_WIDTH{1'b0}}) ? {DATA_WIDTH{1'b0}} : byp1_s;
    byp2_s = (rr2_q == {ADDR_WIDTH{1'b0}}) ? {DATA_WIDTH{1'b0}} : byp2_s;
  end

  // Fetch FSM next-state: latch addresses, wait out the read, capture, hand off.
  always_comb begin
    state_d     = state_q;
    rr1_d       = rr1_q;
    rr2_d       = rr2_q;
    out_rd_d    = out_rd_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          rr1_d    = InRs;
          rr2_d    = InRt;
          out_rd_d = InRd;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        op1_d       = byp1_s;
        op2_d       = byp2_s;
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_RESP;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      rr1_q       <= {ADDR_WIDTH{1'b0}};
      rr2_q       <= {ADDR_WIDTH{1'b0}};
      out_rd_q    <= {ADDR_WIDTH{1'b0}};
      op1_q       <= {DATA_WIDTH{1'b0}};
      op2_q       <= {DATA_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      for (int i = 0; i < WB_DEPTH; i++) begin
        q_reg_q[i]  <= {ADDR_WIDTH{1'b0}};
        q_data_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      rr1_q       <= rr1_d;
      rr2_q       <= rr2_d;
      out_rd_q    <= out_rd_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      out_valid_q <= out_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < WB_DEPTH; i++) begin
        q_reg_q[i]  <= q_reg_d[i];
        q_data_q[i] <= q_data_d[i];
      end
    end
  end

  // Port views of the registered state.
  always_comb begin
    InReady       = (state_q == S_IDLE);
    OutValid      = out_valid_q;
    Op1           = op1_q;
    Op2           = op2_q;
    OutRd         = out_rd_q;
    ReadRegister1 = rr1_q;
    ReadRegister2 = rr2_q;
  end

endmodule

// File: tb/tb_regfile_access_unit.sv
// Directed testbench for regfile_access_unit with a behavioural register file.
module tb_regfile_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid, InReady;
  logic [4:0]  InRs, InRt, InRd;
  logic        OutValid, OutReady;
  logic [31:0] Op1, Op2;
  logic [4:0]  OutRd;
  logic        WbValid, WbReady;
  logic [4:0]  WbReg;
  logic [31:0] WbData;
  logic        Freeze;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        RegWrite;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rf_mem [32];
  logic        zero_write_seen;

  regfile_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WB_DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InRs(InRs), .InRt(InRt), .InRd(InRd),
    .OutValid(OutValid), .OutReady(OutReady), .Op1(Op1), .Op2(Op2), .OutRd(OutRd),
    .WbValid(WbValid), .WbReady(WbReady), .WbReg(WbReg), .WbData(WbData),
    .Freeze(Freeze),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  always #5 Clk = ~Clk;

  // Register file model: synchronous read, same-edge write visible, R0 hardwired to 0.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
      rf_mem[1] <= 32'd4;
      rf_mem[4] <= 32'd2;
      ReadData1 <= 32'd0;
      ReadData2 <= 32'd0;
      zero_write_seen <= 1'b0;
    end else begin
      if (RegWrite && WriteRegister != 5'd0) rf_mem[WriteRegister] <= WriteData;
      if (RegWrite && WriteRegister == 5'd0) zero_write_seen <= 1'b1;
      ReadData1 <= (ReadRegister1 == 5'd0) ? 32'd0 :
                   (RegWrite && WriteRegister == ReadRegister1) ? WriteData : rf_mem[ReadRegister1];
      ReadData2 <= (ReadRegister2 == 5'd0) ? 32'd0 :
                   (RegWrite && WriteRegister == ReadRegister2) ? WriteData : rf_mem[ReadRegister2];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Accept a request and advance to the CAPTURE cycle.
  task automatic fetch_begin(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    int guard = 0;
    while (!InReady && guard < 20) begin
      step();
      guard++;
    end
    check_eq("fetch_inready", {31'd0, InReady}, 32'd1);
    InValid = 1'b1; InRs = rs; InRt = rt; InRd = rd;
    step();                                   // E0
    InValid = 1'b0;
    check_eq("issue_not_valid", {31'd0, OutValid}, 32'd0);
    step();                                   // E1
    check_eq("capture_not_valid", {31'd0, OutValid}, 32'd0);
  endtask

  task automatic fetch_end();
    step();                                   // E2
    check_eq("resp_valid", {31'd0, OutValid}, 32'd1);
  endtask

  task automatic ack();
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    check_eq("ack_valid_low", {31'd0, OutValid}, 32'd0);
    check_eq("ack_inready", {31'd0, InReady}, 32'd1);
  endtask

  task automatic wb_push(input logic [4:0] r, input logic [31:0] d);
    WbValid = 1'b1; WbReg = r; WbData = d;
    step();
    WbValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InRs = 5'd0; InRt = 5'd0; InRd = 5'd0;
    OutReady = 1'b0; WbValid = 1'b0; WbReg = 5'd0; WbData = 32'd0; Freeze = 1'b0;
    step(); step();
    check_eq("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check_eq("rst_inready",  {31'd0, InReady},  32'd1);
    check_eq("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check_eq("rst_wbready",  {31'd0, WbReady},  32'd1);
    check_eq("rst_op1", Op1, 32'd0);
    check_eq("rst_op2", Op2, 32'd0);
    check_eq("rst_outrd", {27'd0, OutRd}, 32'd0);
    check_eq("rst_rr1", {27'd0, ReadRegister1}, 32'd0);
    check_eq("rst_rr2", {27'd0, ReadRegister2}, 32'd0);
    Reset = 1'b0;
    step();

    // Plain fetch from the register file.
    fetch_begin(5'd1, 5'd4, 5'd7);
    fetch_end();
    check_eq("t1_op1", Op1, 32'd4);
    check_eq("t1_op2", Op2, 32'd2);
    check_eq("t1_outrd", {27'd0, OutRd}, 32'd7);
    ack();

    // Frozen queue entry bypassed, then drained once.
    Freeze = 1'b1;
    wb_push(5'd3, 32'hDEADBEEF);
    check_eq("t2_frozen_rw", {31'd0, RegWrite}, 32'd0);
    fetch_begin(5'd3, 5'd0, 5'd1);
    fetch_end();
    check_eq("t2_op1", Op1, 32'hDEADBEEF);
    check_eq("t2_op2", Op2, 32'd0);
    check_eq("t2_rw_still_0", {31'd0, RegWrite}, 32'd0);
    ack();
    Freeze = 1'b0;
    #1;
    check_eq("t2_drain_rw", {31'd0, RegWrite}, 32'd1);
    check_eq("t2_drain_reg", {27'd0, WriteRegister}, 32'd3);
    check_eq("t2_drain_data", WriteData, 32'hDEADBEEF);
    step();
    check_eq("t2_single_pulse", {31'd0, RegWrite}, 32'd0);

    // Two writes to R5 fill the queue; youngest wins; held response stays stable.
    Freeze = 1'b1;
    wb_push(5'd5, 32'h11);
    wb_push(5'd5, 32'h22);
    check_eq("t3_full_wbready", {31'd0, WbReady}, 32'd0);
    fetch_begin(5'd5, 5'd1, 5'd2);
    fetch_end();
    check_eq("t3_op1_young", Op1, 32'h22);
    check_eq("t3_op2", Op2, 32'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_hold_valid", {31'd0, OutValid}, 32'd1);
      check_eq("t3_hold_op1", Op1, 32'h22);
      check_eq("t3_hold_op2", Op2, 32'd4);
      check_eq("t3_hold_inready", {31'd0, InReady}, 32'd0);
    end
    ack();
    Freeze = 1'b0;
    #1;
    check_eq("t3_drain1_rw", {31'd0, RegWrite}, 32'd1);
    check_eq("t3_drain1_reg", {27'd0, WriteRegister}, 32'd5);
    check_eq("t3_drain1_data", WriteData, 32'h11);
    step();
    check_eq("t3_drain2_rw", {31'd0, RegWrite}, 32'd1);
    check_eq("t3_drain2_data", WriteData, 32'h22);
    step();
    check_eq("t3_drained_rw", {31'd0, RegWrite}, 32'd0);
    check_eq("t3_drained_wbready", {31'd0, WbReady}, 32'd1);
    fetch_begin(5'd5, 5'd3, 5'd0);
    fetch_end();
    check_eq("t3_rf_r5", Op1, 32'h22);
    check_eq("t3_rf_r3", Op2, 32'hDEADBEEF);
    ack();

    // Writeback to R0 is accepted and dropped; R0 reads as zero.
    WbValid = 1'b1; WbReg = 5'd0; WbData = 32'hFFFF;
    #1;
    check_eq("t4_r0_wbready", {31'd0, WbReady}, 32'd1);
    step();
    WbValid = 1'b0;
    step(); step(); step();
    check_eq("t4_no_r0_write", {31'd0, zero_write_seen}, 32'd0);
    check_eq("t4_rw_low", {31'd0, RegWrite}, 32'd0);
    fetch_begin(5'd0, 5'd0, 5'd3);
    fetch_end();
    check_eq("t4_op1", Op1, 32'd0);
    check_eq("t4_op2", Op2, 32'd0);
    check_eq("t4_outrd", {27'd0, OutRd}, 32'd3);
    ack();

    // Incoming writeback beats a queued one; captured operands are snapshots.
    Freeze = 1'b1;
    wb_push(5'd1, 32'h55);
    fetch_begin(5'd1, 5'd6, 5'd0);
    WbValid = 1'b1; WbReg = 5'd1; WbData = 32'h99;
    fetch_end();
    WbValid = 1'b0;
    check_eq("t5_op1_incoming", Op1, 32'h99);
    check_eq("t5_op2", Op2, 32'd0);
    Freeze = 1'b0;
    #1;
    check_eq("t5_full_drain_rw", {31'd0, RegWrite}, 32'd1);
    check_eq("t5_full_drain_data", WriteData, 32'h55);
    check_eq("t5_full_wbready", {31'd0, WbReady}, 32'd0);
    step();
    WbValid = 1'b1; WbReg = 5'd1; WbData = 32'hAA;
    #1;
    check_eq("t5_pp_data", WriteData, 32'h99);
    check_eq("t5_pp_wbready", {31'd0, WbReady}, 32'd1);
    step();
    WbValid = 1'b0;
    Freeze = 1'b1;
    check_eq("t5_snap_op1", Op1, 32'h99);
    check_eq("t5_snap_valid", {31'd0, OutValid}, 32'd1);
    wb_push(5'd2, 32'h77);
    check_eq("t5_refull", {31'd0, WbReady}, 32'd0);
    ack();

    // Reset in CAPTURE with a full queue.
    fetch_begin(5'd1, 5'd4, 5'd5);
    Reset = 1'b1;
    Freeze = 1'b0;
    #1;
    check_eq("t6_rst_outvalid", {31'd0, OutValid}, 32'd0);
    check_eq("t6_rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check_eq("t6_rst_wbready",  {31'd0, WbReady},  32'd1);
    check_eq("t6_rst_inready",  {31'd0, InReady},  32'd1);
    check_eq("t6_rst_rr1", {27'd0, ReadRegister1}, 32'd0);
    step(); step();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t6_post_rw", {31'd0, RegWrite}, 32'd0);
      check_eq("t6_post_valid", {31'd0, OutValid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
